// File: rtl/ram_slot_scheduler_if.sv
// Bus bundle between the slot/background requesters and ram_slot_scheduler.
// BG_ADDR_W sets the background address width (RA[19:0] on the card).
// When SCHED_STATS_EN is defined the bundle also carries the grant and
// stall counters.
interface ram_slot_scheduler_if #(
  parameter int BG_ADDR_W = 20
);
  logic                 cpu_ram_sel;
  logic                 cpu_we;
  logic                 bg_req;
  logic                 bg_we;
  logic [BG_ADDR_W-1:0] bg_addr;
  logic [7:0]           bg_wdata;
  logic [7:0]           rd_in;
  logic [2:0]           phase;
  logic                 sync_ok;
  logic                 addr_sel_bg;
  logic                 ram_cs;
  logic                 ram_we;
  logic                 rd_oe_bg;
  logic                 bg_ack;
  logic [7:0]           bg_rdata;
  logic                 bg_busy;
`ifdef SCHED_STATS_EN
  logic [15:0]          bg_grant_cnt;
  logic [15:0]          bg_stall_cnt;

  modport master (
    output cpu_ram_sel, cpu_we, bg_req, bg_we, bg_addr, bg_wdata, rd_in,
    input  phase, sync_ok, addr_sel_bg, ram_cs, ram_we, rd_oe_bg, bg_ack,
           bg_rdata, bg_busy, bg_grant_cnt, bg_stall_cnt
  );

  modport slave (
    input  cpu_ram_sel, cpu_we, bg_req, bg_we, bg_addr, bg_wdata, rd_in,
    output phase, sync_ok, addr_sel_bg, ram_cs, ram_we, rd_oe_bg, bg_ack,
           bg_rdata, bg_busy, bg_grant_cnt, bg_stall_cnt
  );
`else
  modport master (
    output cpu_ram_sel, cpu_we, bg_req, bg_we, bg_addr, bg_wdata, rd_in,
    input  phase, sync_ok, addr_sel_bg, ram_cs, ram_we, rd_oe_bg, bg_ack,
           bg_rdata, bg_busy
  );

  modport slave (
    input  cpu_ram_sel, cpu_we, bg_req, bg_we, bg_addr, bg_wdata, rd_in,
    output phase, sync_ok, addr_sel_bg, ram_cs, ram_we, rd_oe_bg, bg_ack,
           bg_rdata, bg_busy
  );
`endif
endinterface

// File: rtl/ram_slot_scheduler.sv
// Shares the card SRAM between 6502 slot accesses and one background
// requester. A 7M phase counter S locks to the rising edge of the delayed
// PHI1; the background engine owns S1..S3, the CPU owns S5..S7.
// bg_addr/bg_wdata are consumed by the external RA/RD muxes via
// addr_sel_bg/rd_oe_bg. Define SCHED_STATS_EN to add saturating grant and
// stall counters.
module ram_slot_scheduler #(
  parameter int SYNC_TIMEOUT = 15
) (
  input  logic                C7M,
  input  logic                RES,
  input  logic                PHI1,
  ram_slot_scheduler_if.slave bus
);

  localparam int TO_W = $clog2(SYNC_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(SYNC_TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_MAX  = TO_W'(SYNC_TIMEOUT);

  typedef enum logic [1:0] {IDLE, ADDR, STROBE, DONE} bg_state_t;

  logic [2:0]      s;
  logic [2:0]      s_next;
  logic            phi1_reg;
  logic            phi0_seen;
  logic            rise;
  logic            sync_ok;
  logic [TO_W-1:0] to_cnt;
  bg_state_t       state;
  bg_state_t       state_next;
  logic            ack_next;
  logic            bg_ack;
  logic [7:0]      bg_rdata;
  logic            busy;
  logic            cpu_win;

  // A PHI1 rise only counts once PHI1 has been seen low since reset.
  assign rise = PHI1 & ~phi1_reg & phi0_seen;

  // Phase counter next value: load 1 on a rise, park at 0 or 7, else count.
  always_comb begin
    s_next = s + 3'd1;
    if (rise)
      s_next = 3'd1;
    else if (s == 3'd0)
      s_next = 3'd0;
    else if (s == 3'd7)
      s_next = 3'd7;
  end

  // Phase counter, PHI1 edge history and sync-loss timeout.
  always_ff @(posedge C7M or posedge RES) begin
    if (RES) begin
      s         <= 3'd0;
      phi1_reg  <= 1'b0;
      phi0_seen <= 1'b0;
      sync_ok   <= 1'b0;
      to_cnt    <= '0;
    end else begin
      s        <= s_next;
      phi1_reg <= PHI1;
      if (!PHI1)
        phi0_seen <= 1'b1;
      if (rise) begin
        sync_ok <= 1'b1;
        to_cnt  <= '0;
      end else if (s == 3'd7) begin
        if (to_cnt != TO_MAX)
          to_cnt <= to_cnt + TO_W'(1);
        if (to_cnt == TO_LAST)
          sync_ok <= 1'b0;
      end
    end
  end

  // Background FSM next state; a rise always restarts (or aborts) the cycle.
  always_comb begin
    state_next = state;
    ack_next   = 1'b0;
    if (rise) begin
      state_next = (bus.bg_req && sync_ok) ? ADDR : IDLE;
    end else begin
      case (state)
        ADDR:    state_next = STROBE;
        STROBE:  state_next = DONE;
        DONE: begin
          state_next = IDLE;
          ack_next   = 1'b1;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Background FSM state, completion pulse and read-data capture at end of S3.
  always_ff @(posedge C7M or posedge RES) begin
    if (RES) begin
      state    <= IDLE;
      bg_ack   <= 1'b0;
      bg_rdata <= 8'h00;
    end else begin
      state  <= state_next;
      bg_ack <= ack_next;
      if (ack_next && !bus.bg_we)
        bg_rdata <= bus.rd_in;
    end
  end

  assign busy    = (state != IDLE);
  assign cpu_win = sync_ok && (s >= 3'd5);

  // SRAM strobes: background owns S2/S3, CPU owns S5..S7 with a write in S6.
  always_comb begin
    bus.ram_cs = 1'b0;
    bus.ram_we = 1'b0;
    if (state == STROBE || state == DONE)
      bus.ram_cs = 1'b1;
    if (state == STROBE && bus.bg_we)
      bus.ram_we = 1'b1;
    if (cpu_win && bus.cpu_ram_sel)
      bus.ram_cs = 1'b1;
    if (bus.cpu_ram_sel && bus.cpu_we && s == 3'd6)
      bus.ram_we = 1'b1;
  end

  assign bus.phase       = s;
  assign bus.sync_ok     = sync_ok;
  assign bus.addr_sel_bg = busy;
  assign bus.bg_busy     = busy;
  assign bus.rd_oe_bg    = busy & bus.bg_we;
  assign bus.bg_ack      = bg_ack;
  assign bus.bg_rdata    = bg_rdata;

`ifdef SCHED_STATS_EN
  logic [15:0] grant_cnt;
  logic [15:0] stall_cnt;

  // Saturating counts of completed grants and of requests stalled by lost sync.
  always_ff @(posedge C7M or posedge RES) begin
    if (RES) begin
      grant_cnt <= 16'h0000;
      stall_cnt <= 16'h0000;
    end else begin
      if (bg_ack && grant_cnt != 16'hFFFF)
        grant_cnt <= grant_cnt + 16'd1;
      if (bus.bg_req && !sync_ok && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign bus.bg_grant_cnt = grant_cnt;
  assign bus.bg_stall_cnt = stall_cnt;
`endif

endmodule

// File: tb/tb_ram_slot_scheduler.sv
// Directed bench for ram_slot_scheduler: phase lock, background read/write
// slots, CPU window, mid-cycle resync, sync timeout and reset mid-cycle.
module tb_ram_slot_scheduler;

  logic C7M;
  logic RES;
  logic PHI1;

  int checks   = 0;
  int failures = 0;
  int req_left = 0;

  logic [14:1] cs_v, we_v, sel_v, oe_v, ack_v, busy_v, sync_v;
  logic [2:0]  ph [1:14];
  logic        any_busy;

  ram_slot_scheduler_if #(.BG_ADDR_W(20)) bus ();

  ram_slot_scheduler #(.SYNC_TIMEOUT(15)) dut (
    .C7M  (C7M),
    .RES  (RES),
    .PHI1 (PHI1),
    .bus  (bus)
  );

  // 7M clock
  initial C7M = 1'b0;
  always #5 C7M = ~C7M;

  // Bit mask with steps lo..hi of a bus cycle set.
  function automatic logic [14:1] steps(input int lo, input int hi);
    logic [14:1] v;
    v = '0;
    for (int i = lo; i <= hi; i++) v[i] = 1'b1;
    return v;
  endfunction

  task automatic tick();
    @(posedge C7M);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One bus cycle of 14 C7M steps: PHI1 high for steps 1..7 (rise at step 1),
  // low for 8..14. Outputs are logged per step; the requester drops bg_req
  // once its remaining request count reaches zero.
  task automatic applyStimulus(input int first_k);
    cs_v = '0; we_v = '0; sel_v = '0; oe_v = '0; ack_v = '0; busy_v = '0; sync_v = '0;
    for (int k = first_k; k <= 14; k++) begin
      PHI1 = (k <= 7);
      tick();
      cs_v[k]   = bus.ram_cs;
      we_v[k]   = bus.ram_we;
      sel_v[k]  = bus.addr_sel_bg;
      oe_v[k]   = bus.rd_oe_bg;
      ack_v[k]  = bus.bg_ack;
      busy_v[k] = bus.bg_busy;
      sync_v[k] = bus.sync_ok;
      ph[k]     = bus.phase;
      if (bus.bg_ack) begin
        if (req_left > 0) req_left--;
        bus.bg_req = (req_left > 0);
      end
    end
  endtask

  initial begin
    RES = 1'b1;
    PHI1 = 1'b0;
    bus.cpu_ram_sel = 1'b0;
    bus.cpu_we      = 1'b0;
    bus.bg_req      = 1'b0;
    bus.bg_we       = 1'b0;
    bus.bg_addr     = 20'h00000;
    bus.bg_wdata    = 8'h00;
    bus.rd_in       = 8'h00;
    tick();
    tick();

    $display("[TB] reset state");
    checkOutput("rst_phase", bus.phase, 0);
    checkOutput("rst_sync", bus.sync_ok, 0);
    checkOutput("rst_outs", {bus.addr_sel_bg, bus.ram_cs, bus.ram_we, bus.rd_oe_bg, bus.bg_ack, bus.bg_busy}, 0);
    checkOutput("rst_rdata", bus.bg_rdata, 0);

    RES = 1'b0;
    tick();
    tick();
    checkOutput("phase_parked_0", bus.phase, 0);

    $display("[TB] phase lock");
    applyStimulus(1);
    checkOutput("lock_s1", ph[1], 1);
    checkOutput("lock_s4", ph[4], 4);
    checkOutput("lock_s7", ph[7], 7);
    checkOutput("lock_hold7", ph[14], 7);
    checkOutput("lock_sync", sync_v, steps(1, 14));
    checkOutput("lock_nobusy", busy_v, 0);

    $display("[TB] background read");
    bus.bg_we   = 1'b0;
    bus.bg_addr = 20'h12345;
    bus.rd_in   = 8'hA5;
    bus.bg_req  = 1'b1;
    req_left    = 1;
    applyStimulus(1);
    checkOutput("rd_sel", sel_v, steps(1, 3));
    checkOutput("rd_busy", busy_v, steps(1, 3));
    checkOutput("rd_cs", cs_v, steps(2, 3));
    checkOutput("rd_we", we_v, 0);
    checkOutput("rd_oe", oe_v, 0);
    checkOutput("rd_ack", ack_v, steps(4, 4));
    checkOutput("rd_data", bus.bg_rdata, 8'hA5);
    bus.rd_in = 8'h00;

    $display("[TB] three background writes");
    bus.bg_we    = 1'b1;
    bus.bg_wdata = 8'h3C;
    bus.bg_req   = 1'b1;
    req_left     = 3;
    for (int n = 0; n < 3; n++) begin
      applyStimulus(1);
      checkOutput($sformatf("wr%0d_we", n), we_v, steps(2, 2));
      checkOutput($sformatf("wr%0d_oe", n), oe_v, steps(1, 3));
      checkOutput($sformatf("wr%0d_cs", n), cs_v, steps(2, 3));
      checkOutput($sformatf("wr%0d_ack", n), ack_v, steps(4, 4));
    end
    checkOutput("wr_req_dropped", bus.bg_req, 0);
    applyStimulus(1);
    checkOutput("wr_no_fourth", busy_v, 0);
    checkOutput("wr_rdata_held", bus.bg_rdata, 8'hA5);

    $display("[TB] cpu window with background read");
    bus.bg_we       = 1'b0;
    bus.rd_in       = 8'h5A;
    bus.cpu_ram_sel = 1'b1;
    bus.cpu_we      = 1'b1;
    bus.bg_req      = 1'b1;
    req_left        = 1;
    applyStimulus(1);
    checkOutput("cpu_cs", cs_v, steps(2, 3) | steps(5, 14));
    checkOutput("cpu_we", we_v, steps(6, 6));
    checkOutput("cpu_sel", sel_v, steps(1, 3));
    checkOutput("cpu_ack", ack_v, steps(4, 4));
    checkOutput("cpu_rdata", bus.bg_rdata, 8'h5A);
    bus.cpu_ram_sel = 1'b0;
    bus.cpu_we      = 1'b0;

    $display("[TB] resync during strobe");
    bus.bg_we  = 1'b1;
    bus.bg_req = 1'b1;
    req_left   = 1;
    PHI1 = 1'b1;
    tick();
    checkOutput("rs_addr_phase", bus.phase, 1);
    checkOutput("rs_addr_cs", bus.ram_cs, 0);
    PHI1 = 1'b0;
    tick();
    checkOutput("rs_strobe", {bus.ram_cs, bus.ram_we}, 2'b11);
    PHI1 = 1'b1;
    tick();
    checkOutput("rs_abort_strobe", {bus.ram_cs, bus.ram_we, bus.bg_ack}, 3'b000);
    checkOutput("rs_restart", {bus.phase, bus.bg_busy, bus.addr_sel_bg}, {3'd1, 2'b11});
    applyStimulus(2);
    checkOutput("rs_cs", cs_v, steps(2, 3));
    checkOutput("rs_we", we_v, steps(2, 2));
    checkOutput("rs_ack", ack_v, steps(4, 4));

    $display("[TB] sync timeout");
    bus.bg_we  = 1'b0;
    bus.bg_req = 1'b0;
    req_left   = 0;
    any_busy   = 1'b0;
    PHI1 = 1'b1;
    tick();
    for (int i = 2; i <= 21; i++) begin
      tick();
      any_busy |= bus.bg_busy;
    end
    checkOutput("to_sync_before", bus.sync_ok, 1);
    checkOutput("to_phase7", bus.phase, 7);
    tick();
    checkOutput("to_sync_after", bus.sync_ok, 0);
    bus.bg_req = 1'b1;
    req_left   = 1;
    for (int i = 23; i <= 30; i++) begin
      tick();
      any_busy |= bus.bg_busy;
    end
    PHI1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      any_busy |= bus.bg_busy;
    end
    PHI1 = 1'b1;
    tick();
    any_busy |= bus.bg_busy;
    checkOutput("to_resync", {bus.sync_ok, bus.phase}, {1'b1, 3'd1});
    checkOutput("to_no_grant", any_busy, 0);
`ifdef SCHED_STATS_EN
    checkOutput("stall_cnt", bus.bg_stall_cnt, 12);
    checkOutput("grant_cnt", bus.bg_grant_cnt, 6);
`endif

    $display("[TB] reset mid-cycle");
    applyStimulus(2);
    checkOutput("pre_rst_nobusy", busy_v, 0);
    PHI1 = 1'b1;
    tick();
    tick();
    checkOutput("pre_rst_strobe", {bus.ram_cs, bus.bg_busy}, 2'b11);
    #2;
    RES = 1'b1;
    #1;
    checkOutput("mid_rst_outs", {bus.addr_sel_bg, bus.ram_cs, bus.ram_we, bus.rd_oe_bg, bus.bg_ack, bus.bg_busy, bus.sync_ok}, 0);
    checkOutput("mid_rst_phase", bus.phase, 0);
    checkOutput("mid_rst_rdata", bus.bg_rdata, 0);
    tick();
    tick();
    checkOutput("mid_rst_noack", bus.bg_ack, 0);
`ifdef SCHED_STATS_EN
    checkOutput("rst_cnts", {bus.bg_grant_cnt, bus.bg_stall_cnt}, 0);
`endif
    RES  = 1'b0;
    PHI1 = 1'b0;
    bus.bg_req = 1'b0;
    tick();
    tick();
    checkOutput("post_rst", {bus.phase, bus.sync_ok, bus.bg_ack, bus.bg_busy}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_slot_scheduler.md
Name: ram_slot_scheduler

Overview:
- Time-multiplexes the card's shared SRAM (20-bit address, 8-bit data) between Apple II slot accesses and one background requester (e.g. a fill/copy/checksum engine).
- Uses a 7M-clocked phase counter synchronised to the delayed PHI1.
- The background requester is granted the PHI1 portion of each bus cycle; the 6502 keeps the PHI0 portion.
- Sits between the slot register/decode logic and the RA/RD pin muxes.

Parameters:
- BG_ADDR_W, 20, background address width (RA[19:0]).
- SYNC_TIMEOUT, 15, C7M cycles with no PHI1 rise, counted from entering S==7, before sync_ok drops.

Ports:
- C7M, input, 1, 14M/2 system clock; all logic is on posedge.
- RES, input, 1, reset. Asynchronous, active-high.
- PHI1, input, 1, delayed/hold-extended PHI1 (already glitch-filtered upstream).
- cpu_ram_sel, input, 1, slot access to RAM data register decoded (RAMSEL).
- cpu_we, input, 1, 6502 write (inverted nWE).
- bg_req, input, 1, background request; level, held until bg_ack.
- bg_we, input, 1, background write when 1.
- bg_addr, input, BG_ADDR_W, background address; stable while bg_req=1.
- bg_wdata, input, 8, background write data.
- rd_in, input, 8, SRAM data bus (RD) sampled value.
- phase, output, 3, state counter S.
- sync_ok, output, 1, phase counter locked to PHI1.
- addr_sel_bg, output, 1, RA mux selects bg_addr.
- ram_cs, output, 1, SRAM chip select, active-high.
- ram_we, output, 1, SRAM write strobe, active-high.
- rd_oe_bg, output, 1, drive bg_wdata onto RD.
- bg_ack, output, 1, one-cycle completion pulse.
- bg_rdata, output, 8, captured read data; valid with bg_ack.
- bg_busy, output, 1, background cycle in flight.

Behaviour:
- Reset (RES=1, async): all outputs 0. Internal state is cleared: S=0, PHI1reg=0, PHI0seen=0, bg cycle state, and the timeout counter.
- PHI0seen: set on any edge with PHI1=0.
- Phase counter next value:
  - S=1 if PHI1 & ~PHI1reg & PHI0seen;
  - else S stays 0 if S==0;
  - else S stays 7 if S==7;
  - else S+1.
- sync_ok:
  - Set on the first S=1 load.
  - Cleared when S has been 7 for SYNC_TIMEOUT consecutive cycles.
  - Set again on the next resync.
- Background FSM (IDLE, ADDR, STROBE, DONE):
  - IDLE -> ADDR on an edge where next S==1, bg_req=1 and sync_ok=1. bg_busy=1 and addr_sel_bg=1 from ADDR through DONE.
  - ADDR (S1): address setup. ram_cs=0. rd_oe_bg=bg_we.
  - STROBE (S2): ram_cs=1. ram_we=bg_we. rd_oe_bg=bg_we.
  - DONE (S3): ram_cs=1, ram_we=0 (write hold). On a read, capture rd_in into bg_rdata at the end of S3.
  - After DONE: bg_ack=1 for exactly the S4 cycle, then IDLE. bg_rdata holds until the next read capture.
- bg_req sampling and bg_req=0 mid-cycle:
  - bg_req is sampled only at S1 entry. A request arriving at S2..S7 waits for the next S1, giving at most one bg access per bus cycle.
  - If bg_req drops mid-cycle, the cycle still completes and acks.
- Resync mid-cycle (S forced to 1 while in ADDR/STROBE/DONE):
  - Abort the current cycle: ram_cs and ram_we drop the same edge, no ack.
  - Re-enter ADDR if bg_req=1, else IDLE.
- CPU window (S5, S6, S7):
  - addr_sel_bg=0.
  - ram_cs = cpu_ram_sel & sync_ok.
  - ram_we = cpu_ram_sel & cpu_we & (S==6).
  - The bg FSM never drives in this window.
- S==0 or sync_ok=0: no bg grants; CPU path ram_cs=0.
- Reset mid-operation: the cycle is dropped with no bg_ack; the requester re-presents its request.

Optional Feature:
- SCHED_STATS_EN defined:
  - Adds output bg_grant_cnt[15:0], saturating at 16'hFFFF, incremented on each bg_ack.
  - Adds output bg_stall_cnt[15:0], saturating, incremented each cycle bg_req=1 & sync_ok=0.
  - Both clear on RES.
- SCHED_STATS_EN undefined: neither port nor the counters exist.

Test Plan:
- Reset then PHI1 toggling every 7 C7M cycles -> first PHI1 rise after a low gives phase=1, sync_ok=1; phase reaches 7 and holds until the next rise.
- bg_req=1, bg_we=0, bg_addr=20'h12345, rd_in=8'hA5 -> addr_sel_bg=1 S1..S3; ram_cs=1 S2,S3; bg_ack pulse at S4; bg_rdata=8'hA5.
- bg_req=1, bg_we=1, bg_wdata=8'h3C -> ram_we=1 only in S2; rd_oe_bg=1 S1..S3; bg_ack at S4; 3 consecutive requests take exactly 3 bus cycles.
- cpu_ram_sel=1, cpu_we=1 with bg_req=1 -> bg cycle in S1..S3; CPU ram_cs S5..S7 with ram_we only in S6; addr_sel_bg=0 S5..S7; no overlap.
- PHI1 rise forced during STROBE -> ram_cs drops the same edge, no bg_ack, cycle restarts at the new S1 and acks at S4.
- PHI1 held high for 30 cycles -> sync_ok=0 after 15 cycles at S7; bg_req gets no grant; with SCHED_STATS_EN, bg_stall_cnt counts those cycles. RES mid-cycle -> all outputs 0, no ack.
